// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, byte type and baud divisor helper for uart_rx.
// UART_RX_PARITY_EN adds the PARITY state between the data bits and the stop bit.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous FIFO with a registered head output; pointers carry one wrap bit.
module rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_q, rd_q, count;
    logic [AW-1:0]    rd_next;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign rd_next = rd_q[AW-1:0] + 1'b1;
    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = head_q;

    // storage array, written at the tail; needs no reset
    always_ff @(posedge clk_i)
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;

    // pointers advance on accepted push/pop and wrap naturally
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end

    // head register reloads only on a pop or on a push that lands at the head
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) head_q <= '0;
        else if (do_pop && count > (AW+1)'(1)) head_q <= mem_q[rd_next];
        else if (do_push && (empty_o || (do_pop && count == (AW+1)'(1)))) head_q <= push_data_i;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, sticky error flags and receive FIFO.
// Defining UART_RX_PARITY_EN expects an even-parity bit after bit 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_000_000,
    parameter int BAUD        = 100_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       overrun,
    output logic       frame_err,
    input  logic       clr_err
);
    localparam int            CPB  = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int            CW   = $clog2(CPB);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif

    logic [1:0]    sync_q;
    logic          rxs, tick, push, frame_set, pop, fifo_full, fifo_empty, par_bad;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    byte_t         shift_q, shift_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

    assign rxs  = sync_q[1];
    assign tick = cnt_q == ((state_q == S_START) ? HALF : LAST);
    assign pop  = rd_ready && !fifo_empty;

    // two-flop synchronizer, idles high so reset looks like a quiet line
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], RXD};

    // FSM state register
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) state_q <= S_IDLE;
        else state_q <= state_d;

    // FSM next state: mid-bit sampling driven by the bit-period counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = rxs ? S_IDLE : S_START;
            S_START:  state_d = !tick ? S_START : (rxs ? S_IDLE : S_DATA);
            S_DATA:   state_d = (tick && bit_q == 3'd7) ? AFTER_DATA : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_PARITY: state_d = tick ? S_STOP : S_PARITY;
`endif
            S_STOP:   state_d = !tick ? S_STOP : (rxs ? S_IDLE : S_WAIT);
            S_WAIT:   state_d = rxs ? S_IDLE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: push a good byte, flag a bad stop (or parity) sample
    always_comb begin
        push      = state_q == S_STOP && tick && rxs && !par_bad;
        frame_set = state_q == S_STOP && tick && !rxs;
`ifdef UART_RX_PARITY_EN
        frame_set = frame_set || (state_q == S_PARITY && tick && (rxs != ^shift_q));
`endif
    end

    // datapath next state: counter, bit index and LSB-first shift register
    always_comb begin
        cnt_d   = (state_q == S_IDLE || state_q == S_WAIT || tick) ? '0 : cnt_q + 1'b1;
        bit_d   = (state_q == S_DATA) ? bit_q + 3'(tick) : 3'd0;
        shift_d = (state_q == S_DATA && tick) ? {rxs, shift_q[7:1]} : shift_q;
    end

    // datapath registers
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;

    // remembers a parity mismatch so the stop state discards the byte
    always_comb
        par_bad_d = (state_q == S_START) ? 1'b0 :
                    (state_q == S_PARITY && tick && (rxs != ^shift_q)) ? 1'b1 : par_bad_q;

    // parity mismatch register
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) par_bad_q <= 1'b0;
        else par_bad_q <= par_bad_d;

    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    // sticky flags: a new set condition beats a simultaneous clear
    always_comb begin
        overrun_d   = (push && fifo_full && !pop) || (overrun_q && !clr_err);
        frame_err_d = frame_set || (frame_err_q && !clr_err);
    end

    // sticky flag registers
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rd_valid  = !fifo_empty;

    rx_fifo #(
        .WIDTH     (8),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .push_i     (push),
        .push_data_i(shift_q),
        .pop_i      (rd_ready),
        .head_o     (rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the SOC's UART peripheral. Samples the asynchronous `RXD` pin, recovers 8N1 frames at a fixed baud rate, and buffers the received bytes in a small FIFO. The processor's memory-mapped IO stage pops bytes from the FIFO. Framing and overrun errors are recorded in sticky status flags.

## Interface
- `CLK_FREQ_HZ`, default 1_000_000: frequency of `CLK` in Hz.
- `BAUD`, default 100_000: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` must be at least 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, at least 2.
- `CLK` input, 1 bit: the single clock; all logic is clocked on its rising edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `RXD` input, 1 bit: serial line, asynchronous to `CLK`; idles high.
- `rd_data` output, 8 bits: byte at the FIFO head; valid only while `rd_valid` is high.
- `rd_valid` output, 1 bit: FIFO is non-empty.
- `rd_ready` input, 1 bit: pop request; the head is popped on a clock edge where `rd_valid && rd_ready`.
- `overrun` output, 1 bit: sticky flag; a byte was dropped because the FIFO was full.
- `frame_err` output, 1 bit: sticky flag; a stop bit was sampled as 0.
- `clr_err` input, 1 bit: single-cycle pulse that clears both sticky flags.

## Operation
- **Synchronizer.** `RXD` passes through a 2-flop synchronizer whose flops reset to 1. The result is `rxs`. All decisions use `rxs` only.
- **State machine states:** IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY when configured). A bit counter `bitcnt` runs 0..CLKS_PER_BIT-1.
- **IDLE:** when `rxs`=0, go to START and clear the counter.
- **START:** at count CLKS_PER_BIT/2 - 1 (mid start bit), re-check `rxs`.
  - `rxs`=0: go to DATA.
  - `rxs`=1: treat as a glitch and return to IDLE. No flag is set.
- **DATA:** sample `rxs` every CLKS_PER_BIT cycles, 8 samples, LSB first, shifting into an 8-bit register.
- **STOP:** sample one more bit period later.
  - `rxs`=1: push the byte and go to IDLE.
  - `rxs`=0: set `frame_err`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxs`=1, then go to IDLE. A line held low (break) therefore produces exactly one `frame_err` and no bytes.
- **Push when the FIFO is full:** the byte is dropped and `overrun` is set, unless a pop occurs on the same edge. In that case the pop and push both take effect and nothing is dropped.
- **Sticky flags:** if `clr_err` and a set condition occur on the same edge, set wins.
- **Reset values:** `rd_valid`=0, `rd_data`=8'h00, `overrun`=0, `frame_err`=0. The FIFO is empty, the FSM is in IDLE, and the synchronizer flops are 1.
- **Reset mid-frame:** the partial byte is discarded. After release, the receiver restarts in IDLE; if `rxs` is low by then, it starts a new frame.

## Timing
- Let edge E be the first rising edge at which `RXD` is sampled 0 by the first synchronizer flop.
- The FSM leaves IDLE at E+2.
- The start-bit check occurs at E+2+CLKS_PER_BIT/2.
- Data bit k is sampled at E+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at E+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- The push happens on that same stop-sample edge, so `rd_valid` is visible in the following cycle.
- With the default parameters, `rd_valid` rises 97 cycles after E; the flags follow the same timing.
- `rd_data` is the registered FIFO head. It changes only on a push into an empty FIFO or on a pop.
- Back-to-back frames are accepted: after a good stop sample, a falling `rxs` is detected from the next cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit is expected after bit 7.
  - It is sampled in state PARITY, one bit period after bit 7; the stop bit follows one bit period later.
  - A mismatch discards the byte and sets `frame_err`. The FSM then proceeds to STOP normally.
  - Latency grows by CLKS_PER_BIT.
- Macro undefined: 8N1 framing, and no PARITY state exists.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - the `clks_per_bit(freq, baud)` constant function;
  - the byte type.
- Sub-module `rx_fifo` is a synchronous FIFO with a registered head output.
  - Parameters: width and `FIFO_DEPTH`.
  - Ports: push/pop ports plus full/empty.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap around naturally.
- The synchronizer, FSM and flags live in `uart_rx`.

## Test plan
- **Single frame (defaults):** drive 8'hA5 as 8N1 at 10 clocks/bit → `rd_valid` rises 97 cycles after E with `rd_data`=8'hA5. Pop → `rd_valid`=0.
- **Break after reset:** hold `RXD`=0 from reset → exactly one `frame_err` pulse-to-sticky, `rd_valid` stays 0. Release `RXD`=1, send 8'h3C → byte received correctly.
- **Glitch:** a 3-cycle low pulse on `RXD` → FSM returns to IDLE, no flag, no byte.
- **Overrun:** send 5 frames (8'h01..8'h05) without popping → FIFO holds 8'h01..8'h04 and `overrun`=1. Send a 6th frame while popping on the push edge → no further loss.
- **Flag clear:** `clr_err` pulse → both flags 0. `clr_err` on the same edge as a new framing error → `frame_err`=1.
- **Parity (`UART_RX_PARITY_EN`):** 8'h07 with parity bit 1 → accepted. Same byte with parity bit 0 → `frame_err`=1 and no byte.
